// File: rtl/mimc_hash_feeder_pkg.sv
// Shared definitions for the MiMC core sequencers.
//   mimc_feeder_state_t : sequencer states of mimc_hash_feeder
//   timer_width()       : counter width able to hold values 0..n-1 (at least 1 bit)
package mimc_hash_feeder_pkg;

    typedef enum logic [2:0] {
        st_idle,
        st_hrst,
        st_issue,
        st_arm,
        st_busy,
        st_next,
        st_out,
        st_drain
    } mimc_feeder_state_t;

    function automatic int unsigned timer_width(int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mimc_feeder_timer.sv
// Loadable down-counter with an expiry flag.
//   clk, rst      : clock, synchronous active-low reset
//   load, load_val: load the counter (takes priority over dec)
//   dec           : decrement by one, holding at zero
//   expired       : counter is zero
module mimc_feeder_timer #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/mimc_hash_feeder.sv
// Initiator-side sequencer for one mimc_hash core.
//   s_*        : input stream of field elements (valid/ready, s_last closes a message)
//   m_*        : digest output (valid/ready) with the number of absorbed elements
//   err_timeout: sticky, the core missed its done deadline on some element
//   hash_*     : absorb protocol towards the core (rst/en/in out, out/done in)
module mimc_hash_feeder
    import mimc_hash_feeder_pkg::*;
#(
    parameter int unsigned N_BITS         = 254,
    parameter int unsigned MAX_ELEMS      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [N_BITS-1:0]                s_data,
    input  logic                             s_last,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [N_BITS-1:0]                m_digest,
    output logic [$clog2(MAX_ELEMS+1)-1:0]   m_count,
    output logic                             err_timeout,
    output logic                             hash_rst,
    output logic                             hash_en,
    output logic [N_BITS-1:0]                hash_in,
    input  logic [N_BITS-1:0]                hash_out,
    input  logic                             hash_done
);

    localparam int unsigned CNT_W = $clog2(MAX_ELEMS + 1);
    localparam int unsigned TMR_W = timer_width(TIMEOUT_CYCLES);

    mimc_feeder_state_t state_q, state_d;

    logic [N_BITS-1:0] hash_in_q;
    logic [N_BITS-1:0] digest_q;
    logic [CNT_W-1:0]  count_q;
    logic              last_q;
    logic              err_q;
    logic              tmo_rst_q;

    logic accept_state;
    logic latch;
    logic done_ok;
    logic tmo_fire;
    logic tmr_expired;

    // Deadline counter: loaded while issuing, so ARM entry corresponds to an
    // elapsed count of 0 and expiry to TIMEOUT_CYCLES-1.
    mimc_feeder_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == st_issue),
        .load_val (TMR_W'(TIMEOUT_CYCLES - 1)),
        .dec      ((state_q == st_arm) || (state_q == st_busy)),
        .expired  (tmr_expired)
    );

    assign accept_state = (state_q == st_idle) || (state_q == st_next) ||
                          (state_q == st_drain);
    // Elements seen in DRAIN are consumed but never latched.
    assign latch = s_valid && ((state_q == st_idle) || (state_q == st_next));

    always_comb begin
        state_d  = state_q;
        done_ok  = 1'b0;
        tmo_fire = 1'b0;
        unique case (state_q)
            st_idle:  if (s_valid) state_d = st_hrst;
            st_hrst:  state_d = st_issue;
            st_issue: state_d = st_arm;
            st_arm: begin
                // A done still high from the previous element is stale.
                if (tmr_expired) begin
                    tmo_fire = 1'b1;
                end else if (!hash_done) begin
                    state_d = st_busy;
                end
            end
            st_busy: begin
                if (hash_done) begin
                    done_ok = 1'b1;
                    state_d = last_q ? st_out : st_next;
                end else if (tmr_expired) begin
                    tmo_fire = 1'b1;
                end
            end
            st_next:  if (s_valid) state_d = st_issue;
            st_out:   if (m_ready) state_d = st_idle;
            st_drain: if (s_valid && s_last) state_d = st_idle;
            default:  state_d = st_idle;
        endcase
        if (tmo_fire) begin
            state_d = last_q ? st_idle : st_drain;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= st_idle;
            hash_in_q <= '0;
            digest_q  <= '0;
            count_q   <= '0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            tmo_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_rst_q <= tmo_fire;
            if (latch) begin
                hash_in_q <= s_data;
                last_q    <= s_last;
            end
            if (done_ok && (count_q != CNT_W'(MAX_ELEMS))) begin
                count_q <= count_q + 1'b1;
            end
            if (done_ok && last_q) begin
                digest_q <= hash_out;
            end
            if (tmo_fire || ((state_q == st_out) && m_ready)) begin
                count_q <= '0;
            end
            if (tmo_fire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign s_ready     = rst && accept_state;
    assign m_valid     = (state_q == st_out);
    assign m_digest    = digest_q;
    assign m_count     = count_q;
    assign err_timeout = err_q;
    // Timeout reset is registered so no combinational path runs from
    // hash_done back into hash_rst.
    assign hash_rst    = !rst || (state_q == st_hrst) || tmo_rst_q;
    assign hash_en     = (state_q == st_issue);
    assign hash_in     = hash_in_q;

endmodule

// File: tb/tb_mimc_hash_feeder.sv
module tb_mimc_hash_feeder;

    localparam int unsigned NB = 254;
    localparam int unsigned ME = 5;
    localparam int unsigned TO = 16;
    localparam int unsigned CW = $clog2(ME + 1);

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [NB-1:0] s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [NB-1:0] m_digest;
    logic [CW-1:0] m_count;
    logic          err_timeout;
    logic          hash_rst;
    logic          hash_en;
    logic [NB-1:0] hash_in;
    logic [NB-1:0] hash_out;
    logic          hash_done;

    mimc_hash_feeder #(
        .N_BITS         (NB),
        .MAX_ELEMS      (ME),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_digest    (m_digest),
        .m_count     (m_count),
        .err_timeout (err_timeout),
        .hash_rst    (hash_rst),
        .hash_en     (hash_en),
        .hash_in     (hash_in),
        .hash_out    (hash_out),
        .hash_done   (hash_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Order-sensitive chaining function standing in for one MiMC absorb.
    function automatic logic [NB-1:0] mix(input logic [NB-1:0] h, input logic [NB-1:0] x);
        logic [NB-1:0] r;
        r = {h[NB-2:0], h[NB-1]};
        return (r ^ x) + 254'h9e3779b97f4a7c15_0123456789abcdef;
    endfunction

    function automatic logic [NB-1:0] rand_fe();
        logic [255:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return r[NB-1:0];
    endfunction

    // ---------------- behavioural core stub ----------------
    logic [NB-1:0] core_h;
    logic [NB-1:0] core_pend;
    logic          core_done;
    logic          core_busy;
    int            core_lat = 0;
    bit            stuck = 1'b0;
    int            fix_lat = 0;

    // done stays high after completion and only drops one cycle after the next
    // en, so the feeder sees a stale done right after issuing.
    always @(posedge clk) begin
        if (hash_rst) begin
            core_h    <= '0;
            core_done <= 1'b0;
            core_busy <= 1'b0;
        end else if (hash_en) begin
            core_pend <= hash_in;
            core_busy <= 1'b1;
            core_lat  <= (fix_lat != 0) ? fix_lat : 2 + int'($urandom_range(0, 4));
        end else if (core_busy) begin
            if (core_lat <= 1) begin
                core_busy <= 1'b0;
                if (!stuck) begin
                    core_h    <= mix(core_h, core_pend);
                    core_done <= 1'b1;
                end
            end else begin
                core_lat  <= core_lat - 1;
                core_done <= 1'b0;
            end
        end
    end

    assign hash_out  = core_h;
    assign hash_done = core_done;

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [NB-1:0] d;
        int unsigned   c;
    } exp_t;

    exp_t sb[$];
    int   n_en = 0;
    int   rst_pulses = 0;

    initial begin
        exp_t          e;
        logic          held;
        logic [NB-1:0] held_d;
        logic [CW-1:0] held_c;
        logic          rst_prev;
        held = 1'b0;
        held_d = '0;
        held_c = '0;
        rst_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_digest: got %h want none", m_digest);
                end else begin
                    e = sb.pop_front();
                    check("digest", 256'(m_digest), 256'(e.d));
                    check("count", 256'(m_count), 256'(e.c));
                end
                held = 1'b0;
            end else if (m_valid) begin
                if (held) begin
                    check("hold_digest", 256'(m_digest), 256'(held_d));
                    check("hold_count", 256'(m_count), 256'(held_c));
                end
                held = 1'b1;
                held_d = m_digest;
                held_c = m_count;
            end else begin
                held = 1'b0;
            end
            if (hash_en) begin
                n_en++;
                check("en_with_rst", 256'(hash_rst), 256'(0));
            end
            if (rst && hash_rst && !rst_prev) rst_pulses++;
            rst_prev = hash_rst;
        end
    end

    int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    logic [NB-1:0] msg_q[$];

    task automatic send_elem(input logic [NB-1:0] d, input bit last);
        bit ok;
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_wait: got no s_ready want s_ready within 400 cycles");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat ($urandom_range(0, 1)) @(posedge clk);
    endtask

    task automatic send_msg();
        exp_t          e;
        logic [NB-1:0] h;
        h = '0;
        foreach (msg_q[i]) h = mix(h, msg_q[i]);
        e.d = h;
        e.c = (msg_q.size() > ME) ? ME : msg_q.size();
        sb.push_back(e);
        foreach (msg_q[i]) send_elem(msg_q[i], i == msg_q.size() - 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL digest_wait: got %0d pending want 0", sb.size());
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    logic [NB-1:0] t1, t2, t3;
    int            p0, e0, k;

    initial begin
        t1 = 254'h1d4c_0a22_7f31_9b6e_5e03_c8d1_2a7b_44f0;
        t2 = 254'h2f00_1bad_c0de_7777_0000_1111_dead_beef_0123;
        t3 = 254'h0abc_def0_1234_5678_9abc_def0_0fed_cba9;
        rst = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 256'(s_ready), 256'(0));
        check("rst_m_valid", 256'(m_valid), 256'(0));
        check("rst_m_digest", 256'(m_digest), 256'(0));
        check("rst_m_count", 256'(m_count), 256'(0));
        check("rst_err", 256'(err_timeout), 256'(0));
        check("rst_hash_en", 256'(hash_en), 256'(0));
        check("rst_hash_in", 256'(hash_in), 256'(0));
        check("rst_hash_rst", 256'(hash_rst), 256'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("idle_s_ready", 256'(s_ready), 256'(1));

        // Three-element message, one core reset
        p0 = rst_pulses;
        msg_q = '{t1, t2, t3};
        send_msg();
        wait_done();
        check("one_hash_rst", 256'(rst_pulses - p0), 256'(1));

        // Same message back to back
        send_msg();
        send_msg();
        wait_done();

        // Single element
        msg_q = '{t1};
        send_msg();
        wait_done();

        // Random messages with random back-pressure
        rdy_mode = 1;
        for (int m = 0; m < 6; m++) begin
            msg_q.delete();
            for (int j = 0; j < int'($urandom_range(1, 4)); j++) msg_q.push_back(rand_fe());
            send_msg();
        end
        wait_done();
        rdy_mode = 0;

        // Count saturation
        msg_q.delete();
        for (int j = 0; j < 7; j++) msg_q.push_back(rand_fe());
        send_msg();
        wait_done();

        // Held output
        rdy_mode = 2;
        msg_q = '{t3, t2};
        send_msg();
        for (int i = 0; i < 500 && !m_valid; i++) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_m_valid", 256'(m_valid), 256'(1));
            check("hold_s_ready", 256'(s_ready), 256'(0));
        end
        rdy_mode = 0;
        wait_done();

        // Timeout on a non-last element, then drain
        stuck = 1'b1;
        p0 = rst_pulses;
        send_elem(t1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hash_en) break;
        end
        k = 0;
        for (int i = 0; i < 60 && !err_timeout; i++) begin
            @(negedge clk);
            k++;
        end
        check("timeout_latency", 256'(k), 256'(TO + 1));
        repeat (2) @(posedge clk);
        check("timeout_rst_pulses", 256'(rst_pulses - p0), 256'(2));
        e0 = n_en;
        send_elem(t2, 1'b0);
        send_elem(t3, 1'b1);
        repeat (3) @(posedge clk);
        check("drain_no_en", 256'(n_en - e0), 256'(0));
        check("err_sticky", 256'(err_timeout), 256'(1));
        stuck = 1'b0;
        msg_q = '{t2, t1};
        send_msg();
        wait_done();

        // Timeout on the last element goes straight back to IDLE
        stuck = 1'b1;
        send_elem(t3, 1'b1);
        repeat (30) @(posedge clk);
        stuck = 1'b0;
        msg_q = '{t1, t3};
        send_msg();
        wait_done();

        // Reset while the second element is in BUSY
        fix_lat = 6;
        send_elem(t1, 1'b0);
        send_elem(t2, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hash_en) break;
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_s_ready", 256'(s_ready), 256'(0));
        check("mid_m_valid", 256'(m_valid), 256'(0));
        check("mid_m_digest", 256'(m_digest), 256'(0));
        check("mid_m_count", 256'(m_count), 256'(0));
        check("mid_err", 256'(err_timeout), 256'(0));
        check("mid_hash_en", 256'(hash_en), 256'(0));
        check("mid_hash_in", 256'(hash_in), 256'(0));
        check("mid_hash_rst", 256'(hash_rst), 256'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        fix_lat = 0;
        msg_q = '{t1, t2, t3};
        send_msg();
        wait_done();

        repeat (5) @(posedge clk);
        check("sb_empty", 256'(sb.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
